// File: rtl/brick_pkg.sv
// Shared constants, FSM encoding and spawn data for the brick sprite position controller.
// The BRICK_LFSR_SPAWN_EN build uses the LFSR seed and taps defined here.
package brick_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int SPR_W      = 87;
  localparam int SPR_H      = 86;
  localparam int HIT_FRAMES = 32;

  localparam logic [10:0] MAX_COL   = 11'(H_ACTIVE - SPR_W);
  localparam logic [10:0] MAX_ROW   = 11'(V_ACTIVE - SPR_H);
  localparam logic [10:0] DX        = 11'd3;
  localparam logic [10:0] DY        = 11'd1;
  localparam logic [10:0] SPAWN_ROW = 11'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_HIT   = 2'd2,
    ST_SPAWN = 2'd3
  } state_t;

  localparam logic [2:0] SPAWN_LAST = 3'd4;
  localparam logic [9:0] LFSR_SEED  = 10'h2A5;
  localparam int         LFSR_TAP_A = 9;  // tap 10
  localparam int         LFSR_TAP_B = 6;  // tap 7

  function automatic logic [10:0] spawn_table(input logic [2:0] idx);
    case (idx)
      3'd0:    return 11'd0;
      3'd1:    return 11'd140;
      3'd2:    return 11'd280;
      3'd3:    return 11'd420;
      default: return MAX_COL;
    endcase
  endfunction

endpackage

// File: rtl/brick_spawn_gen.sv
// Spawn column source: a 5-entry table walked by advance, or a free-running
// 10-bit LFSR when BRICK_LFSR_SPAWN_EN is defined.
module brick_spawn_gen
  import brick_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [10:0] col
);

`ifdef BRICK_LFSR_SPAWN_EN
  logic [9:0]  lfsr;
  logic [10:0] raw;
  logic        unused_advance;

  // The LFSR free-runs every clock, so advance carries no information here.
  assign unused_advance = advance;

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[8:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
  end

  assign raw = {1'b0, lfsr};
  assign col = (raw < MAX_COL) ? raw : raw - MAX_COL;
`else
  logic [2:0] idx;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)       idx <= 3'd0;
    else if (advance) idx <= (idx == SPAWN_LAST) ? 3'd0 : idx + 3'd1;
  end

  assign col = spawn_table(idx);
`endif

endmodule

// File: rtl/brick_mover.sv
// Brick sprite position controller: per-frame bounce/fall, hit blink, escape pulse.
// Optional LFSR spawn columns with BRICK_LFSR_SPAWN_EN.
module brick_mover
  import brick_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        hit,
  output logic [10:0] b_col,
  output logic [10:0] b_row,
  output logic        visible,
  output logic        escaped,
  output logic [7:0]  hit_count,
  output logic [1:0]  state
);

  state_t      st, st_n;
  logic        dir_left, dir_left_n;
  logic [10:0] col_n, row_n;
  logic        vis_n, esc_n;
  logic [7:0]  hits_n;
  logic [4:0]  frames, frames_n;
  logic [10:0] spawn_col;

  brick_spawn_gen u_spawn (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (st == ST_SPAWN),
    .col     (spawn_col)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    st_n       = st;
    col_n      = b_col;
    row_n      = b_row;
    dir_left_n = dir_left;
    vis_n      = visible;
    esc_n      = 1'b0;
    hits_n     = hit_count;
    frames_n   = frames;

    case (st)
      ST_IDLE: begin
        vis_n = 1'b1;
        if (start) st_n = ST_SPAWN;
      end

      ST_SPAWN: begin
        col_n      = spawn_col;
        row_n      = SPAWN_ROW;
        dir_left_n = (spawn_col >= MAX_COL / 11'd2);
        vis_n      = 1'b1;
        st_n       = ST_MOVE;
      end

      ST_MOVE: begin
        if (hit) begin
          // A hit swallows any same-cycle movement or escape.
          st_n     = ST_HIT;
          hits_n   = (hit_count == 8'hFF) ? hit_count : hit_count + 8'd1;
          frames_n = 5'd0;
        end else if (frame_tick) begin
          if (!dir_left) begin
            if (b_col + DX >= MAX_COL) begin
              col_n      = MAX_COL;
              dir_left_n = 1'b1;
            end else begin
              col_n = b_col + DX;
            end
          end else if (b_col <= DX) begin
            col_n      = 11'd0;
            dir_left_n = 1'b0;
          end else begin
            col_n = b_col - DX;
          end

          if (b_row + DY > MAX_ROW) begin
            esc_n = 1'b1;
            st_n  = ST_SPAWN;
          end else begin
            row_n = b_row + DY;
          end
        end
      end

      ST_HIT: begin
        if (frame_tick) begin
          frames_n = frames + 5'd1;
          vis_n    = ~frames[2];
          if (frames == 5'(HIT_FRAMES - 1)) st_n = ST_SPAWN;
        end
      end

      default: st_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      b_col     <= 11'd0;
      b_row     <= SPAWN_ROW;
      dir_left  <= 1'b0;
      visible   <= 1'b1;
      escaped   <= 1'b0;
      hit_count <= 8'd0;
      frames    <= 5'd0;
    end else begin
      st        <= st_n;
      b_col     <= col_n;
      b_row     <= row_n;
      dir_left  <= dir_left_n;
      visible   <= vis_n;
      escaped   <= esc_n;
      hit_count <= hits_n;
      frames    <= frames_n;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_brick_mover.sv
// Self-checking bench for brick_mover (default build): directed scenarios plus
// randomized stimulus against a behavioural model of the brick.
module tb_brick_mover;

  logic        clk = 1'b0;
  logic        rst_n, frame_tick, start, hit;
  logic [10:0] b_col, b_row;
  logic        visible, escaped;
  logic [7:0]  hit_count;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  // Behavioural model: mode 0 idle, 1 moving, 2 hit, 3 spawning.
  int m_mode, m_col, m_row, m_idx, m_frames, m_hits;
  bit m_right, m_vis, m_esc;
  int spawn_cols[5] = '{0, 140, 280, 420, 553};

  brick_mover dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start      (start),
    .hit        (hit),
    .b_col      (b_col),
    .b_row      (b_row),
    .visible    (visible),
    .escaped    (escaped),
    .hit_count  (hit_count),
    .state      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish in time (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic model_edge();
    if (!rst_n) begin
      m_mode = 0; m_col = 0; m_row = 0; m_right = 1; m_vis = 1;
      m_esc = 0; m_hits = 0; m_frames = 0; m_idx = 0;
    end else begin
      m_esc = 0;
      case (m_mode)
        0: begin
          m_vis = 1;
          if (start) m_mode = 3;
        end
        3: begin
          m_col   = spawn_cols[m_idx];
          m_idx   = (m_idx + 1) % 5;
          m_row   = 0;
          m_right = (m_col < 553 / 2);
          m_vis   = 1;
          m_mode  = 1;
        end
        1: begin
          if (hit) begin
            m_mode   = 2;
            m_hits   = (m_hits < 255) ? m_hits + 1 : 255;
            m_frames = 0;
          end else if (frame_tick) begin
            if (m_right) begin
              if (m_col + 3 >= 553) begin m_col = 553; m_right = 0; end
              else m_col = m_col + 3;
            end else begin
              if (m_col <= 3) begin m_col = 0; m_right = 1; end
              else m_col = m_col - 3;
            end
            if (m_row + 1 > 394) begin m_esc = 1; m_mode = 3; end
            else m_row = m_row + 1;
          end
        end
        default: begin
          if (frame_tick) begin
            m_vis = ((m_frames / 4) % 2) == 0;
            if (m_frames == 31) m_mode = 3;
            m_frames = m_frames + 1;
          end
        end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // One quiet cycle then one frame_tick cycle; outputs reflect the tick on return.
  task automatic tick();
    frame_tick = 1'b0;
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; hit = 1'b0; frame_tick = 1'b0;
    step(); step();
    rst_n = 1'b1;
    total++;
    if (b_col !== 11'd0 || b_row !== 11'd0 || visible !== 1'b1 || escaped !== 1'b0 ||
        hit_count !== 8'd0 || state !== 2'd0) begin
      bad++;
      $display("FAIL reset: got col=%0d row=%0d vis=%b esc=%b hits=%0d st=%0d want 0 0 1 0 0 0",
               b_col, b_row, visible, escaped, hit_count, state);
    end
    hit = 1'b1; frame_tick = 1'b1;
    step();
    hit = 1'b0; frame_tick = 1'b0;
    step();
    total++;
    if (state !== 2'd0 || hit_count !== 8'd0 || b_col !== 11'd0) begin
      bad++;
      $display("FAIL idle_ignores_hit: got st=%0d hits=%0d col=%0d want 0 0 0", state, hit_count, b_col);
    end
  endtask

  task automatic test_start();
    start = 1'b1;
    step();
    total++;
    if (state !== 2'd3) begin
      bad++;
      $display("FAIL start_to_spawn: got st=%0d want 3", state);
    end
    start = 1'b0;
    hit = 1'b1;
    step();
    hit = 1'b0;
    total++;
    if (state !== 2'd1 || b_col !== 11'd0 || b_row !== 11'd0 || hit_count !== 8'd0) begin
      bad++;
      $display("FAIL first_spawn: got st=%0d col=%0d row=%0d hits=%0d want 1 0 0 0",
               state, b_col, b_row, hit_count);
    end
    ticks(5);
    total++;
    if (b_col !== 11'd15 || b_row !== 11'd5) begin
      bad++;
      $display("FAIL five_ticks: got col=%0d row=%0d want 15 5", b_col, b_row);
    end
  endtask

  task automatic test_escape();
    ticks(389);
    total++;
    if (b_row !== 11'd394 || escaped !== 1'b0 || state !== 2'd1) begin
      bad++;
      $display("FAIL at_bottom: got row=%0d esc=%b st=%0d want 394 0 1", b_row, escaped, state);
    end
    tick();
    total++;
    if (escaped !== 1'b1 || b_row !== 11'd394 || state !== 2'd3) begin
      bad++;
      $display("FAIL escape_pulse: got esc=%b row=%0d st=%0d want 1 394 3", escaped, b_row, state);
    end
    step();
    total++;
    if (escaped !== 1'b0 || state !== 2'd1 || b_col !== 11'd140 || b_row !== 11'd0) begin
      bad++;
      $display("FAIL respawn: got esc=%b st=%0d col=%0d row=%0d want 0 1 140 0",
               escaped, state, b_col, b_row);
    end
  endtask

  task automatic test_right_bounce();
    ticks(137);
    total++;
    if (b_col !== 11'd551) begin
      bad++;
      $display("FAIL near_right: got col=%0d want 551", b_col);
    end
    tick();
    total++;
    if (b_col !== 11'd553) begin
      bad++;
      $display("FAIL right_clamp: got col=%0d want 553", b_col);
    end
    tick();
    total++;
    if (b_col !== 11'd550) begin
      bad++;
      $display("FAIL right_rebound: got col=%0d want 550", b_col);
    end
  endtask

  task automatic test_hit();
    ticks(150);
    frame_tick = 1'b0;
    step();
    frame_tick = 1'b1; hit = 1'b1;
    step();
    frame_tick = 1'b0; hit = 1'b0;
    total++;
    if (state !== 2'd2 || b_col !== 11'd100 || b_row !== 11'd289 || hit_count !== 8'd1 ||
        escaped !== 1'b0) begin
      bad++;
      $display("FAIL hit_entry: got st=%0d col=%0d row=%0d hits=%0d esc=%b want 2 100 289 1 0",
               state, b_col, b_row, hit_count, escaped);
    end
    for (int i = 0; i < 32; i++) begin
      logic exp_vis;
      logic [1:0] exp_st;
      exp_vis = ((i / 4) % 2) == 0;
      exp_st  = (i == 31) ? 2'd3 : 2'd2;
      hit = 1'b1;
      step();
      hit = 1'b0; frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      total++;
      if (visible !== exp_vis || state !== exp_st || b_col !== 11'd100) begin
        bad++;
        $display("FAIL hit_blink[%0d]: got vis=%b st=%0d col=%0d want %b %0d 100",
                 i, visible, state, b_col, exp_vis, exp_st);
      end
    end
    total++;
    if (hit_count !== 8'd1) begin
      bad++;
      $display("FAIL hit_ignored_in_hit: got hits=%0d want 1", hit_count);
    end
    step();
    total++;
    if (state !== 2'd1 || b_col !== 11'd280 || b_row !== 11'd0 || visible !== 1'b1) begin
      bad++;
      $display("FAIL hit_respawn: got st=%0d col=%0d row=%0d vis=%b want 1 280 0 1",
               state, b_col, b_row, visible);
    end
  endtask

  task automatic test_left_bounce();
    ticks(93);
    total++;
    if (b_col !== 11'd1) begin
      bad++;
      $display("FAIL near_left: got col=%0d want 1", b_col);
    end
    tick();
    tick();
    total++;
    if (b_col !== 11'd3) begin
      bad++;
      $display("FAIL left_rebound_a: got col=%0d want 3", b_col);
    end
    // Recover through a hit to reach the 420 spawn, then bounce off exactly col 3.
    step();
    hit = 1'b1;
    step();
    hit = 1'b0;
    ticks(32);
    step();
    total++;
    if (b_col !== 11'd420 || hit_count !== 8'd2 || state !== 2'd1) begin
      bad++;
      $display("FAIL spawn_420: got col=%0d hits=%0d st=%0d want 420 2 1", b_col, hit_count, state);
    end
    ticks(139);
    total++;
    if (b_col !== 11'd3) begin
      bad++;
      $display("FAIL at_three: got col=%0d want 3", b_col);
    end
    tick();
    total++;
    if (b_col !== 11'd0) begin
      bad++;
      $display("FAIL left_clamp: got col=%0d want 0", b_col);
    end
    tick();
    total++;
    if (b_col !== 11'd3) begin
      bad++;
      $display("FAIL left_rebound_b: got col=%0d want 3", b_col);
    end
  endtask

  task automatic test_random();
    bit last_tick = 0;
    for (int c = 0; c < 4000; c++) begin
      frame_tick = !last_tick && ($urandom_range(0, 2) == 0);
      hit        = ($urandom_range(0, 39) == 0);
      start      = $urandom_range(0, 1);
      last_tick  = frame_tick;
      step();
      total++;
      if (b_col !== 11'(m_col) || b_row !== 11'(m_row) || visible !== m_vis ||
          escaped !== m_esc || hit_count !== 8'(m_hits) || state !== 2'(m_mode)) begin
        bad++;
        $display("FAIL random[%0d]: got col=%0d row=%0d vis=%b esc=%b hits=%0d st=%0d want %0d %0d %b %b %0d %0d",
                 c, b_col, b_row, visible, escaped, hit_count, state,
                 m_col, m_row, m_vis, m_esc, m_hits, m_mode);
      end
    end
    frame_tick = 1'b0; hit = 1'b0; start = 1'b0;
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 260; n++) begin
      int guard = 0;
      while (m_mode != 1 && guard < 80) begin
        tick();
        guard++;
      end
      step();
      hit = 1'b1;
      step();
      hit = 1'b0;
      total++;
      if (state !== 2'd2 || hit_count !== 8'(m_hits)) begin
        bad++;
        $display("FAIL sat_hit[%0d]: got st=%0d hits=%0d want 2 %0d", n, state, hit_count, m_hits);
      end
      if (n < 259) begin
        ticks(32);
        step();
      end
    end
    total++;
    if (hit_count !== 8'd255) begin
      bad++;
      $display("FAIL saturate: got hits=%0d want 255", hit_count);
    end
    ticks(5);
    total++;
    if (state !== 2'd2 || visible !== 1'b0) begin
      bad++;
      $display("FAIL mid_hit: got st=%0d vis=%b want 2 0", state, visible);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++;
    if (b_col !== 11'd0 || b_row !== 11'd0 || visible !== 1'b1 || escaped !== 1'b0 ||
        hit_count !== 8'd0 || state !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid_hit: got col=%0d row=%0d vis=%b esc=%b hits=%0d st=%0d want 0 0 1 0 0 0",
               b_col, b_row, visible, escaped, hit_count, state);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; hit = 1'b0; frame_tick = 1'b0;
    test_reset();
    test_start();
    test_escape();
    test_right_bounce();
    test_hit();
    test_left_bounce();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
